// File: rtl/panda_top_tb.sv
// Position-capture (PCAP) arm/capture controller.
// The host arms a capture, framed samples are counted up to a programmed
// total, and completion or a host disarm raises a level interrupt.
// Everything runs on FCLK with a synchronous active-low reset.
module panda_top_tb #(
  parameter int CNT_W  = 16,
  parameter int FLAG_W = 8
) (
  input  logic        FCLK,
  input  logic        tb_ARESETn,
  input  logic        reg_wr_i,
  input  logic        reg_rd_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  input  logic        sample_i,
  input  logic [31:0] frame_i,
  output logic        pcap_armed,
  output logic        pcap_completed,
  output logic        irq_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    count_r;
  logic [31:0]         mask_r;
  logic [31:0]         total_r;
  logic [FLAG_W-1:0]   flags_r;
  logic                completed_r;
  logic                irq_r;
  logic [31:0]         rdata_r;

  logic                armed_s;
  logic                arm_wr_s;
  logic                disarm_wr_s;
  logic                mask_wr_s;
  logic                total_wr_s;
  logic                status_rd_s;
  logic                frame_ok_s;
  logic                accept_s;
  logic                count_sat_s;
  logic [CNT_W-1:0]    count_inc_s;
  logic [31:0]         count_ext_s;
  logic                complete_s;
  logic [FLAG_W-1:0]   flag_set_s;
  logic [FLAG_W-1:0]   flags_next_s;
  logic [31:0]         rd_data_s;

  assign armed_s     = (state_r == ST_ARMED);

  // Register-bus strobe decode.
  assign arm_wr_s    = reg_wr_i && (reg_addr_i == 4'd0);
  assign disarm_wr_s = reg_wr_i && (reg_addr_i == 4'd1);
  assign mask_wr_s   = reg_wr_i && (reg_addr_i == 4'd2);
  assign total_wr_s  = reg_wr_i && (reg_addr_i == 4'd3);
  assign status_rd_s = reg_rd_i && (reg_addr_i == 4'd4);

  // An empty mask lets every strobe through; otherwise at least one masked
  // field must be valid. An ARM write in the same cycle blocks the sample.
  assign frame_ok_s  = (mask_r == 32'd0) || ((frame_i & mask_r) != 32'd0);
  assign accept_s    = armed_s && sample_i && frame_ok_s && !arm_wr_s;

  // Counter saturates at all-ones instead of wrapping.
  assign count_sat_s = (count_r == {CNT_W{1'b1}});
  assign count_inc_s = count_sat_s ? count_r : (count_r + CNT_W'(1));
  assign count_ext_s = {{(32-CNT_W){1'b0}}, count_inc_s};

  // A zero total means run until disarmed.
  assign complete_s  = accept_s && (total_r != 32'd0) && (count_ext_s == total_r);

  // Flag sources for this cycle; a set on the read-clear edge wins.
  always_comb begin
    flag_set_s    = {FLAG_W{1'b0}};
    flag_set_s[0] = complete_s;
    flag_set_s[1] = disarm_wr_s && armed_s;
    flag_set_s[2] = arm_wr_s && armed_s;
    flag_set_s[3] = accept_s && count_sat_s;
  end

  assign flags_next_s = (status_rd_s ? {FLAG_W{1'b0}} : flags_r) | flag_set_s;

  // Read-data mux over the pre-edge register values.
  always_comb begin
    rd_data_s = 32'd0;
    case (reg_addr_i)
      4'd2:    rd_data_s = mask_r;
      4'd3:    rd_data_s = total_r;
      4'd4:    rd_data_s = {count_r, 8'h00, flags_r};
      4'd5:    rd_data_s = {{(32-CNT_W){1'b0}}, count_r};
      4'd6:    rd_data_s = {31'd0, armed_s};
      default: rd_data_s = 32'd0;
    endcase
  end

  // Capture FSM: arm/disarm/complete, sample counter and completion pulse.
  always_ff @(posedge FCLK) begin
    if (!tb_ARESETn) begin
      state_r     <= ST_IDLE;
      count_r     <= {CNT_W{1'b0}};
      completed_r <= 1'b0;
    end else begin
      completed_r <= complete_s;
      case (state_r)
        ST_IDLE: begin
          if (arm_wr_s) begin
            state_r <= ST_ARMED;
            count_r <= {CNT_W{1'b0}};
          end
        end
        ST_ARMED: begin
          if (accept_s) begin
            count_r <= count_inc_s;
          end
          if (complete_s || disarm_wr_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Host-programmable framing mask and sample total.
  always_ff @(posedge FCLK) begin
    if (!tb_ARESETn) begin
      mask_r  <= 32'd0;
      total_r <= 32'd0;
    end else begin
      if (mask_wr_s) begin
        mask_r <= reg_wdata_i;
      end
      if (total_wr_s) begin
        total_r <= reg_wdata_i;
      end
    end
  end

  // Sticky IRQ flags with read-to-clear, and the registered interrupt level.
  always_ff @(posedge FCLK) begin
    if (!tb_ARESETn) begin
      flags_r <= {FLAG_W{1'b0}};
      irq_r   <= 1'b0;
    end else begin
      flags_r <= flags_next_s;
      irq_r   <= |flags_next_s;
    end
  end

  // Read data is captured one cycle after the read strobe and held.
  always_ff @(posedge FCLK) begin
    if (!tb_ARESETn) begin
      rdata_r <= 32'd0;
    end else if (reg_rd_i) begin
      rdata_r <= rd_data_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign reg_rdata_o    = rdata_r;
  assign pcap_armed     = armed_s;
  assign pcap_completed = completed_r;
  assign irq_o          = irq_r;

endmodule

// File: tb/tb_panda_top_tb.sv
// Self-checking bench for the PCAP arm/capture controller: directed
// scenarios with fixed expected values, then randomized traffic checked
// cycle-by-cycle against a behavioural model of the register-level rules.
module tb_panda_top_tb;

  logic        FCLK = 1'b0;
  logic        tb_ARESETn;
  logic        reg_wr_i;
  logic        reg_rd_i;
  logic [3:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        sample_i;
  logic [31:0] frame_i;
  logic        pcap_armed;
  logic        pcap_completed;
  logic        irq_o;

  always #5 FCLK = ~FCLK;

  panda_top_tb dut (
    .FCLK           (FCLK),
    .tb_ARESETn     (tb_ARESETn),
    .reg_wr_i       (reg_wr_i),
    .reg_rd_i       (reg_rd_i),
    .reg_addr_i     (reg_addr_i),
    .reg_wdata_i    (reg_wdata_i),
    .reg_rdata_o    (reg_rdata_o),
    .sample_i       (sample_i),
    .frame_i        (frame_i),
    .pcap_armed     (pcap_armed),
    .pcap_completed (pcap_completed),
    .irq_o          (irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (register-level view of the controller).
  bit          m_armed;
  int unsigned m_count;
  int unsigned m_total;
  logic [31:0] m_mask;
  logic [7:0]  m_flags;
  bit          m_comp;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one clock edge's worth of inputs to the model.
  task automatic model_step(input bit rstn, input bit wr, input bit rd, input logic [3:0] addr,
                            input logic [31:0] wdata, input bit smp, input logic [31:0] frame);
    bit         nxt_armed;
    bit         acc;
    logic [7:0] f;
    logic [15:0] c16;
    if (!rstn) begin
      m_armed = 0; m_count = 0; m_total = 0; m_mask = 32'd0;
      m_flags = 8'd0; m_comp = 0; m_rdata = 32'd0;
    end else begin
      nxt_armed = m_armed;
      f         = m_flags;
      m_comp    = 0;
      c16       = m_count[15:0];
      if (rd) begin
        case (addr)
          4'd2:    m_rdata = m_mask;
          4'd3:    m_rdata = m_total;
          4'd4:    m_rdata = {c16, 8'h00, m_flags};
          4'd5:    m_rdata = m_count;
          4'd6:    m_rdata = {31'd0, m_armed};
          default: m_rdata = 32'd0;
        endcase
        if (addr == 4'd4) f = 8'd0;
      end
      acc = m_armed && smp && !(wr && addr == 4'd0) &&
            (m_mask == 32'd0 || (frame & m_mask) != 32'd0);
      if (acc) begin
        if (m_count == 65535) f[3] = 1'b1;
        else m_count = m_count + 1;
        if (m_total != 0 && m_count == m_total) begin
          m_comp = 1; f[0] = 1'b1; nxt_armed = 0;
        end
      end
      if (wr) begin
        case (addr)
          4'd0: if (m_armed) f[2] = 1'b1; else begin nxt_armed = 1; m_count = 0; end
          4'd1: if (m_armed) begin f[1] = 1'b1; nxt_armed = 0; end
          4'd2: m_mask = wdata;
          4'd3: m_total = wdata;
          default: ;
        endcase
      end
      m_armed = nxt_armed;
      m_flags = f;
    end
  endtask

  // Drive one cycle, step the model at the edge, then compare outputs.
  task automatic cyc(input bit rstn, input bit wr, input bit rd, input logic [3:0] addr,
                     input logic [31:0] wdata, input bit smp, input logic [31:0] frame);
    tb_ARESETn  = rstn;
    reg_wr_i    = wr;
    reg_rd_i    = rd;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    sample_i    = smp;
    frame_i     = frame;
    @(posedge FCLK);
    model_step(rstn, wr, rd, addr, wdata, smp, frame);
    #1;
    chk("armed", pcap_armed, m_armed);
    chk("completed", pcap_completed, m_comp);
    chk("irq", irq_o, (m_flags != 8'd0));
    if (rd || !rstn) chk("rdata", reg_rdata_o, m_rdata);
    tb_ARESETn = 1'b1;
    reg_wr_i   = 1'b0;
    reg_rd_i   = 1'b0;
    sample_i   = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
    cyc(1, 1, 0, addr, data, 0, 32'd0);
  endtask

  task automatic smp(input logic [31:0] frame);
    cyc(1, 0, 0, 4'd0, 32'd0, 1, frame);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 4'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic rd_exp(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    cyc(1, 0, 1, addr, 32'd0, 0, 32'd0);
    chk(tag, reg_rdata_o, exp);
  endtask

  initial begin
    logic [31:0] masks [5];
    tb_ARESETn = 1'b0; reg_wr_i = 1'b0; reg_rd_i = 1'b0; reg_addr_i = 4'd0;
    reg_wdata_i = 32'd0; sample_i = 1'b0; frame_i = 32'd0;

    // 1: reset held four cycles
    repeat (4) cyc(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
    chk("t1_armed", pcap_armed, 32'd0);
    chk("t1_irq", irq_o, 32'd0);
    rd_exp("t1_status", 4'd4, 32'd0);
    rd_exp("t1_count", 4'd5, 32'd0);

    // 2: basic capture of 10 unframed samples
    wr_reg(4'd3, 32'd10);
    wr_reg(4'd2, 32'd0);
    wr_reg(4'd0, 32'd0);
    chk("t2_armed", pcap_armed, 32'd1);
    for (int i = 0; i < 10; i++) begin
      smp($urandom);
      if (i < 9) chk("t2_nocomp", pcap_completed, 32'd0);
    end
    chk("t2_comp", pcap_completed, 32'd1);
    chk("t2_disarmed", pcap_armed, 32'd0);
    idle();
    chk("t2_pulse_end", pcap_completed, 32'd0);
    chk("t2_irq", irq_o, 32'd1);
    rd_exp("t2_status", 4'd4, 32'h000A0001);
    rd_exp("t2_status2", 4'd4, 32'h000A0000);
    chk("t2_irq_clr", irq_o, 32'd0);

    // 3: framing mask selects every other sample
    wr_reg(4'd2, 32'h4);
    wr_reg(4'd3, 32'd5);
    wr_reg(4'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      smp((i % 2 == 0) ? 32'h4 : 32'h1);
      if (i == 8) chk("t3_comp", pcap_completed, 32'd1);
      if (i < 8) chk("t3_nocomp", pcap_completed, 32'd0);
    end
    rd_exp("t3_count", 4'd5, 32'd5);
    rd_exp("t3_status", 4'd4, 32'h00050001);

    // 4: disarm with unlimited total
    wr_reg(4'd3, 32'd0);
    wr_reg(4'd0, 32'd0);
    repeat (3) smp(32'h4);
    wr_reg(4'd1, 32'd0);
    chk("t4_armed", pcap_armed, 32'd0);
    chk("t4_nocomp", pcap_completed, 32'd0);
    rd_exp("t4_status", 4'd4, 32'h00030002);

    // 5: re-arm error, with a sample coinciding with the second ARM
    wr_reg(4'd0, 32'd0);
    repeat (2) smp(32'h4);
    cyc(1, 1, 0, 4'd0, 32'd0, 1, 32'h4);
    chk("t5_armed", pcap_armed, 32'd1);
    rd_exp("t5_count", 4'd5, 32'd2);
    rd_exp("t5_state", 4'd6, 32'd1);
    rd_exp("t5_status", 4'd4, 32'h00020004);
    wr_reg(4'd1, 32'd0);
    rd_exp("t5_status2", 4'd4, 32'h00020002);

    // 6: reset in the middle of a capture
    wr_reg(4'd3, 32'd4);
    wr_reg(4'd0, 32'd0);
    repeat (2) smp(32'h4);
    cyc(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
    chk("t6_armed", pcap_armed, 32'd0);
    chk("t6_nocomp", pcap_completed, 32'd0);
    rd_exp("t6_count", 4'd5, 32'd0);
    rd_exp("t6_total", 4'd3, 32'd0);
    rd_exp("t6_mask", 4'd2, 32'd0);
    wr_reg(4'd3, 32'd4);
    wr_reg(4'd0, 32'd0);
    repeat (4) smp(32'd0);
    chk("t6_comp", pcap_completed, 32'd1);
    rd_exp("t6_status", 4'd4, 32'h00040001);

    // 7: DISARM and completing sample in the same cycle
    wr_reg(4'd3, 32'd2);
    wr_reg(4'd0, 32'd0);
    smp(32'd0);
    cyc(1, 1, 0, 4'd1, 32'd0, 1, 32'd0);
    chk("t7_comp", pcap_completed, 32'd1);
    rd_exp("t7_status", 4'd4, 32'h00020003);

    // 8: counter saturation, and unmapped address behaviour
    wr_reg(4'd9, 32'hDEADBEEF);
    rd_exp("t8_unmapped", 4'd9, 32'd0);
    wr_reg(4'd3, 32'h00010000);
    wr_reg(4'd0, 32'd0);
    repeat (65536) smp(32'd0);
    chk("t8_armed", pcap_armed, 32'd1);
    rd_exp("t8_status", 4'd4, 32'hFFFF0008);
    wr_reg(4'd1, 32'd0);

    // Randomized traffic against the model
    masks[0] = 32'h0; masks[1] = 32'h1; masks[2] = 32'h4; masks[3] = 32'h5; masks[4] = $urandom;
    for (int n = 0; n < 2000; n++) begin
      int unsigned op;
      logic [31:0] wd;
      logic [3:0]  ad;
      bit          s;
      op = $urandom_range(0, 99);
      s  = ($urandom_range(0, 2) != 0);
      ad = 4'($urandom_range(0, 9));
      wd = $urandom;
      if (op == 0) begin
        cyc(0, 0, 0, 4'd0, 32'd0, s, 32'($urandom_range(0, 7)));
      end else if (op < 8) begin
        cyc(1, 1, 0, 4'd0, wd, s, 32'($urandom_range(0, 7)));
      end else if (op < 11) begin
        cyc(1, 1, 0, 4'd1, wd, s, 32'($urandom_range(0, 7)));
      end else if (op < 14) begin
        cyc(1, 1, 0, 4'd2, masks[$urandom_range(0, 4)], s, 32'($urandom_range(0, 7)));
      end else if (op < 18) begin
        wd = ($urandom_range(0, 15) == 0) ? 32'h00010000 : 32'($urandom_range(0, 12));
        cyc(1, 1, 0, 4'd3, wd, s, 32'($urandom_range(0, 7)));
      end else if (op < 20) begin
        cyc(1, 1, 0, ad, wd, s, 32'($urandom_range(0, 7)));
      end else if (op < 35) begin
        cyc(1, 0, 1, ad, 32'd0, s, 32'($urandom_range(0, 7)));
      end else begin
        cyc(1, 0, 0, 4'd0, 32'd0, s, 32'($urandom_range(0, 7)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
